// File: rtl/dcache_lowx_arb_if.sv
// dcache_lowx_arb_if: dcache lower-level memory (lowx) request/response bus.
// master = arbiter side, slave = lowx bus adapter side.
interface dcache_lowx_arb_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned BLK_SIZE = 128
);

    logic                lowx_req_valid_o;
    logic                lowx_req_ready_i;
    logic [XLEN-1:0]     lowx_req_addr_o;
    logic [BLK_SIZE-1:0] lowx_req_data_o;
    logic                lowx_req_we_o;
    logic                lowx_res_valid_i;
    logic [BLK_SIZE-1:0] lowx_res_data_i;
    logic                lowx_res_ready_o;

    modport master (
        output lowx_req_valid_o,
        output lowx_req_addr_o,
        output lowx_req_data_o,
        output lowx_req_we_o,
        output lowx_res_ready_o,
        input  lowx_req_ready_i,
        input  lowx_res_valid_i,
        input  lowx_res_data_i
    );

    modport slave (
        input  lowx_req_valid_o,
        input  lowx_req_addr_o,
        input  lowx_req_data_o,
        input  lowx_req_we_o,
        input  lowx_res_ready_o,
        output lowx_req_ready_i,
        output lowx_res_valid_i,
        output lowx_res_data_i
    );

endinterface

// File: rtl/dcache_lowx_arb.sv
// dcache_lowx_arb: shares the single dcache lowx port between eviction writeback (ev),
// fence.i writeback (fi) and line refill (rf). Fixed priority ev > fi > rf; one lowx
// transaction (request handshake then response handshake) in flight at a time.
// Optional macro DCACHE_ARB_AGING_EN: refill starvation counter that promotes rf to top
// priority once it has been passed over AGE_MAX times.
module dcache_lowx_arb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned BLK_SIZE = 128,
    parameter int unsigned AGE_MAX  = 15
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                ev_req_i,
    input  logic [XLEN-1:0]     ev_addr_i,
    input  logic [BLK_SIZE-1:0] ev_data_i,
    output logic                ev_gnt_o,
    output logic                ev_done_o,

    input  logic                fi_req_i,
    input  logic [XLEN-1:0]     fi_addr_i,
    input  logic [BLK_SIZE-1:0] fi_data_i,
    output logic                fi_gnt_o,
    output logic                fi_done_o,

    input  logic                rf_req_i,
    input  logic [XLEN-1:0]     rf_addr_i,
    output logic                rf_gnt_o,
    output logic                rf_done_o,
    output logic [BLK_SIZE-1:0] rf_rdata_o,

    dcache_lowx_arb_if.master   lowx,

    output logic                busy_o
);

    // Line offset bits are cleared so lowx always sees line-aligned addresses.
    localparam int unsigned     OffW     = $clog2(BLK_SIZE / 8);
    localparam logic [XLEN-1:0] AddrMask = ~((XLEN'(1) << OffW) - XLEN'(1));

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRes} state_e;
    typedef enum logic [1:0] {OwnNone, OwnEv, OwnFi, OwnRf} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              win;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [BLK_SIZE-1:0] data_q, data_d;
    logic                we_q, we_d;
    logic [BLK_SIZE-1:0] rdata_q, rdata_d;
    logic                res_hs;
    logic                rf_first;

`ifdef DCACHE_ARB_AGING_EN
    logic [3:0] rf_age_q, rf_age_d;

    // rf jumps the queue once it has been passed over often enough.
    assign rf_first = rf_req_i && (32'(rf_age_q) >= AGE_MAX);

    // Count arbitrations won by ev/fi while rf waits; saturate at the counter limit.
    always_comb begin
        rf_age_d = rf_age_q;
        if (win == OwnRf) begin
            rf_age_d = 4'd0;
        end else if ((win == OwnEv || win == OwnFi) && rf_req_i && rf_age_q != 4'hF) begin
            rf_age_d = rf_age_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_age_q <= 4'd0;
        end else begin
            rf_age_q <= rf_age_d;
        end
    end
`else
    assign rf_first = 1'b0;
`endif

    // Winner selection; only meaningful while idle.
    always_comb begin
        win = OwnNone;
        if (state_q == StIdle) begin
            if (rf_first) begin
                win = OwnRf;
            end else if (ev_req_i) begin
                win = OwnEv;
            end else if (fi_req_i) begin
                win = OwnFi;
            end else if (rf_req_i) begin
                win = OwnRf;
            end
        end
    end

    assign res_hs = (state_q == StWaitRes) && lowx.lowx_res_valid_i;

    // Next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (win != OwnNone) state_d = StIssue;
            StIssue:   if (lowx.lowx_req_ready_i) state_d = StWaitRes;
            StWaitRes: if (lowx.lowx_res_valid_i) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Capture the winner's request fields at grant; held stable until the next grant.
    always_comb begin
        owner_d = owner_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        unique case (win)
            OwnEv: begin
                owner_d = OwnEv;
                addr_d  = ev_addr_i & AddrMask;
                data_d  = ev_data_i;
                we_d    = 1'b1;
            end
            OwnFi: begin
                owner_d = OwnFi;
                addr_d  = fi_addr_i & AddrMask;
                data_d  = fi_data_i;
                we_d    = 1'b1;
            end
            OwnRf: begin
                owner_d = OwnRf;
                addr_d  = rf_addr_i & AddrMask;
                data_d  = '0;
                we_d    = 1'b0;
            end
            default: ;
        endcase
    end

    // Refill data is kept until the next refill completes.
    always_comb begin
        rdata_d = rdata_q;
        if (res_hs && owner_q == OwnRf) begin
            rdata_d = lowx.lowx_res_data_i;
        end
    end

    // State and latched-request registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            owner_q <= OwnNone;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    assign ev_gnt_o  = (win == OwnEv);
    assign fi_gnt_o  = (win == OwnFi);
    assign rf_gnt_o  = (win == OwnRf);

    assign ev_done_o = res_hs && (owner_q == OwnEv);
    assign fi_done_o = res_hs && (owner_q == OwnFi);
    assign rf_done_o = res_hs && (owner_q == OwnRf);

    assign rf_rdata_o = rdata_q;
    assign busy_o     = (state_q != StIdle);

    assign lowx.lowx_req_valid_o = (state_q == StIssue);
    assign lowx.lowx_req_addr_o  = addr_q;
    assign lowx.lowx_req_data_o  = data_q;
    assign lowx.lowx_req_we_o    = we_q;
    assign lowx.lowx_res_ready_o = (state_q == StWaitRes);

endmodule

// File: tb/tb_dcache_lowx_arb.sv
// tb_dcache_lowx_arb: directed bench for dcache_lowx_arb with a scoreboard of expected
// lowx transactions (pushed when a request is driven, popped when the DUT issues it).
module tb_dcache_lowx_arb;

    localparam int unsigned XW = 32;
    localparam int unsigned BW = 128;

    logic          clk;
    logic          rst_n;
    logic          ev_req, fi_req, rf_req;
    logic [XW-1:0] ev_addr, fi_addr, rf_addr;
    logic [BW-1:0] ev_data, fi_data;
    logic          ev_gnt, fi_gnt, rf_gnt;
    logic          ev_done, fi_done, rf_done;
    logic [BW-1:0] rf_rdata;
    logic          busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          owner;  // 0 ev, 1 fi, 2 rf
        logic [31:0] addr;
        logic [127:0] data;
        logic        we;
    } exp_t;

    exp_t exp_q[$];

    dcache_lowx_arb_if #(.XLEN(XW), .BLK_SIZE(BW)) bus ();

    dcache_lowx_arb #(
        .XLEN    (XW),
        .BLK_SIZE(BW),
        .AGE_MAX (2)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .ev_req_i  (ev_req),
        .ev_addr_i (ev_addr),
        .ev_data_i (ev_data),
        .ev_gnt_o  (ev_gnt),
        .ev_done_o (ev_done),
        .fi_req_i  (fi_req),
        .fi_addr_i (fi_addr),
        .fi_data_i (fi_data),
        .fi_gnt_o  (fi_gnt),
        .fi_done_o (fi_done),
        .rf_req_i  (rf_req),
        .rf_addr_i (rf_addr),
        .rf_gnt_o  (rf_gnt),
        .rf_done_o (rf_done),
        .rf_rdata_o(rf_rdata),
        .lowx      (bus),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected transaction as seen on lowx: line-aligned address, zero data for reads.
    task automatic push_exp(input int owner, input logic [31:0] a, input logic [127:0] d);
        exp_t e;
        e.owner = owner;
        e.addr  = a & 32'hFFFF_FFF0;
        e.data  = (owner == 2) ? 128'd0 : d;
        e.we    = (owner != 2);
        exp_q.push_back(e);
    endtask

    // who: 0 ev, 1 fi, 2 rf, -1 none
    task automatic check_gnt(input string tag, input int who);
        check({tag, "_ev_gnt"}, {127'd0, ev_gnt}, {127'd0, who == 0});
        check({tag, "_fi_gnt"}, {127'd0, fi_gnt}, {127'd0, who == 1});
        check({tag, "_rf_gnt"}, {127'd0, rf_gnt}, {127'd0, who == 2});
    endtask

    task automatic check_done(input string tag, input int who);
        check({tag, "_ev_done"}, {127'd0, ev_done}, {127'd0, who == 0});
        check({tag, "_fi_done"}, {127'd0, fi_done}, {127'd0, who == 1});
        check({tag, "_rf_done"}, {127'd0, rf_done}, {127'd0, who == 2});
    endtask

    // Called in the grant cycle. Plays the lowx side: accept after rdy_wait stall cycles,
    // respond after res_wait idle cycles in WAIT_RES. Returns in the following idle cycle
    // (already sampled), so the caller can check the next grant there.
    task automatic serve(input int rdy_wait, input int res_wait, input logic [127:0] rdata,
                         input bit early_res, input bit drop);
        exp_t e;
        bit   hs;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 128'd1, 128'd0);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i <= rdy_wait; i++) begin
            @(negedge clk);
            bus.lowx_req_ready_i = (i == rdy_wait);
            bus.lowx_res_valid_i = early_res;
            bus.lowx_res_data_i  = rdata;
            #1;
            check("issue_valid", {127'd0, bus.lowx_req_valid_o}, 128'd1);
            check("issue_addr", {96'd0, bus.lowx_req_addr_o}, {96'd0, e.addr});
            check("issue_data", bus.lowx_req_data_o, e.data);
            check("issue_we", {127'd0, bus.lowx_req_we_o}, {127'd0, e.we});
            check("issue_res_ready", {127'd0, bus.lowx_res_ready_o}, 128'd0);
            check("issue_busy", {127'd0, busy}, 128'd1);
            check_done("issue", -1);
        end
        for (int i = 0; i <= res_wait; i++) begin
            hs = early_res || (i == res_wait);
            @(negedge clk);
            bus.lowx_req_ready_i = 1'b0;
            bus.lowx_res_valid_i = hs;
            bus.lowx_res_data_i  = rdata;
            #1;
            check("wait_valid", {127'd0, bus.lowx_req_valid_o}, 128'd0);
            check("wait_res_ready", {127'd0, bus.lowx_res_ready_o}, 128'd1);
            check_done("wait", hs ? e.owner : -1);
            if (hs) break;
        end
        @(negedge clk);
        bus.lowx_res_valid_i = 1'b0;
        if (drop) begin
            case (e.owner)
                0:       ev_req = 1'b0;
                1:       fi_req = 1'b0;
                default: rf_req = 1'b0;
            endcase
        end
        #1;
        check_done("after", -1);
        check("after_busy", {127'd0, busy}, 128'd0);
        if (e.owner == 2) check("rf_rdata", rf_rdata, rdata);
    endtask

    initial begin
        rst_n   = 1'b0;
        ev_req  = 1'b0; fi_req = 1'b0; rf_req = 1'b0;
        ev_addr = '0;   fi_addr = '0;  rf_addr = '0;
        ev_data = '0;   fi_data = '0;
        bus.lowx_req_ready_i = 1'b0;
        bus.lowx_res_valid_i = 1'b0;
        bus.lowx_res_data_i  = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", {127'd0, bus.lowx_req_valid_o}, 128'd0);
        check("rst_addr", {96'd0, bus.lowx_req_addr_o}, 128'd0);
        check("rst_res_ready", {127'd0, bus.lowx_res_ready_o}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_rdata", rf_rdata, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single refill: grant same cycle, aligned address, response after 2 cycles.
        @(negedge clk);
        rf_req  = 1'b1;
        rf_addr = 32'h8000_0014;
        push_exp(2, rf_addr, '0);
        #1;
        check_gnt("t1", 2);
        check("t1_busy", {127'd0, busy}, 128'd0);
        serve(0, 2, {16{8'hA5}}, 1'b0, 1'b1);
        check_gnt("t1_end", -1);

        // ev, fi, rf together: served in that order.
        @(negedge clk);
        ev_req = 1'b1; ev_addr = 32'h1000_0020; ev_data = {4{32'hE0E0_0001}};
        fi_req = 1'b1; fi_addr = 32'h2000_003C; fi_data = {4{32'hF1F1_0002}};
        rf_req = 1'b1; rf_addr = 32'h3000_0048;
        push_exp(0, ev_addr, ev_data);
        push_exp(1, fi_addr, fi_data);
        push_exp(2, rf_addr, '0);
        #1;
        check_gnt("t2_a", 0);
        serve(1, 0, '0, 1'b0, 1'b1);
        check_gnt("t2_b", 1);
        serve(0, 1, '0, 1'b0, 1'b1);
        check_gnt("t2_c", 2);
        serve(0, 0, {4{32'h5A5A_1234}}, 1'b0, 1'b1);
        check_gnt("t2_end", -1);

        // Request ready held low 5 cycles: fields stable for 6 cycles, single accept.
        @(negedge clk);
        ev_req = 1'b1; ev_addr = 32'h4000_0107; ev_data = {2{64'hDEAD_BEEF_0BAD_F00D}};
        push_exp(0, ev_addr, ev_data);
        #1;
        check_gnt("t3", 0);
        serve(5, 1, '0, 1'b0, 1'b1);
        check("t3_rdata_held", rf_rdata, {4{32'h5A5A_1234}});

        // Response offered during ISSUE is not consumed until WAIT_RES.
        @(negedge clk);
        fi_req = 1'b1; fi_addr = 32'h5000_0000; fi_data = {4{32'h0F0F_CAFE}};
        push_exp(1, fi_addr, fi_data);
        #1;
        check_gnt("t4", 1);
        serve(2, 0, {4{32'h1111_2222}}, 1'b1, 1'b1);

        // Asynchronous reset in WAIT_RES.
        @(negedge clk);
        rf_req = 1'b1; rf_addr = 32'h6000_0010;
        push_exp(2, rf_addr, '0);
        #1;
        check_gnt("t5", 2);
        void'(exp_q.pop_front());
        @(negedge clk);
        bus.lowx_req_ready_i = 1'b1;
        #1;
        check("t5_issue", {127'd0, bus.lowx_req_valid_o}, 128'd1);
        @(negedge clk);
        bus.lowx_req_ready_i = 1'b0;
        #1;
        check("t5_wait", {127'd0, bus.lowx_res_ready_o}, 128'd1);
        #2;
        rst_n  = 1'b0;
        rf_req = 1'b0;
        #1;
        check("t5_valid", {127'd0, bus.lowx_req_valid_o}, 128'd0);
        check("t5_res_ready", {127'd0, bus.lowx_res_ready_o}, 128'd0);
        check("t5_busy", {127'd0, busy}, 128'd0);
        check("t5_addr", {96'd0, bus.lowx_req_addr_o}, 128'd0);
        check("t5_data", bus.lowx_req_data_o, 128'd0);
        check("t5_we", {127'd0, bus.lowx_req_we_o}, 128'd0);
        check("t5_rdata", rf_rdata, 128'd0);
        check_done("t5_rst", -1);
        check_gnt("t5_rst", -1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.lowx_res_valid_i = 1'b1;
        bus.lowx_res_data_i  = {4{32'h7777_7777}};
        #1;
        check_done("t5_post", -1);
        check("t5_post_res_ready", {127'd0, bus.lowx_res_ready_o}, 128'd0);
        check("t5_post_busy", {127'd0, busy}, 128'd0);
        @(negedge clk);
        bus.lowx_res_valid_i = 1'b0;
        #1;
        check("t5_post_rdata", rf_rdata, 128'd0);

        // fi requests continuously while rf is held.
        @(negedge clk);
        fi_req = 1'b1; fi_addr = 32'h7000_0020; fi_data = {4{32'hABCD_0001}};
        rf_req = 1'b1; rf_addr = 32'h7100_0030;
`ifdef DCACHE_ARB_AGING_EN
        push_exp(1, fi_addr, fi_data);
        push_exp(1, fi_addr, fi_data);
        push_exp(2, rf_addr, '0);
        push_exp(1, fi_addr, fi_data);
        #1;
        check_gnt("t6_1", 1);
        serve(0, 0, '0, 1'b0, 1'b0);
        check_gnt("t6_2", 1);
        serve(0, 0, '0, 1'b0, 1'b0);
        check_gnt("t6_3", 2);
        serve(0, 0, {4{32'h3333_4444}}, 1'b0, 1'b1);
        check_gnt("t6_4", 1);
        serve(0, 0, '0, 1'b0, 1'b1);
`else
        push_exp(1, fi_addr, fi_data);
        push_exp(1, fi_addr, fi_data);
        push_exp(1, fi_addr, fi_data);
        push_exp(2, rf_addr, '0);
        #1;
        check_gnt("t6_1", 1);
        serve(0, 0, '0, 1'b0, 1'b0);
        check_gnt("t6_2", 1);
        serve(0, 0, '0, 1'b0, 1'b0);
        check_gnt("t6_3", 1);
        serve(0, 0, '0, 1'b0, 1'b1);
        check_gnt("t6_4", 2);
        serve(0, 0, {4{32'h3333_4444}}, 1'b0, 1'b1);
`endif
        check_gnt("t6_end", -1);
        check("sb_drained", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
